// File: rtl/gpu_cmd_pkg.sv
// rtl/gpu_cmd_pkg.sv - shared opcode and FSM state types for the command decoder
package gpu_cmd_pkg;

  typedef enum logic [1:0] {
    OP_LINE  = 2'b00,
    OP_RECT  = 2'b01,
    OP_POINT = 2'b10,
    OP_CLEAR = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    ISSUE = 2'b10
  } state_t;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/gpu_cmd_decoder_fifo.sv
// rtl/gpu_cmd_decoder_fifo.sv - synchronous command FIFO with registered read port
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = rd_data_q;

  // Guard internally so a misbehaving producer/consumer cannot corrupt the pointers.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/gpu_cmd_decoder.sv
// rtl/gpu_cmd_decoder.sv - queued draw command decoder: FIFO, range check, normalisation, draw handshake
module gpu_cmd_decoder
  import gpu_cmd_pkg::*;
#(
  parameter int COORD_W = 9,
  parameter int COLOR_W = 8,
  parameter int X_MAX   = 319,
  parameter int Y_MAX   = 239,
  parameter int DEPTH   = 4,
  localparam int CMD_W  = 2 + 4*COORD_W + COLOR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CMD_W-1:0]     cmd_data,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic [COORD_W-1:0]   x1,
  output logic [COORD_W-1:0]   y1,
  output logic [COORD_W-1:0]   x2,
  output logic [COORD_W-1:0]   y2,
  output logic [COLOR_W-1:0]   color,
  output logic [1:0]           draw_mode,
  output logic                 draw_valid,
  input  logic                 draw_ready,
  output logic                 cmd_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);

  state_t state_q, state_d;

  logic             fifo_push, fifo_pop;
  logic [CMD_W-1:0] fifo_rd_data;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign cmd_ready = !fifo_full && !reset;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (cmd_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // The FIFO read register doubles as the latched raw command seen in CHECK.
  opcode_t              raw_op;
  logic [COORD_W-1:0]   raw_x1, raw_y1, raw_x2, raw_y2;
  logic [COLOR_W-1:0]   raw_color;

  assign raw_op    = opcode_t'(fifo_rd_data[CMD_W-1 -: 2]);
  assign raw_x1    = fifo_rd_data[CMD_W-3 -: COORD_W];
  assign raw_y1    = fifo_rd_data[CMD_W-3-COORD_W -: COORD_W];
  assign raw_x2    = fifo_rd_data[CMD_W-3-2*COORD_W -: COORD_W];
  assign raw_y2    = fifo_rd_data[CMD_W-3-3*COORD_W -: COORD_W];
  assign raw_color = fifo_rd_data[COLOR_W-1:0];

  logic [COORD_W-1:0] norm_x1, norm_y1, norm_x2, norm_y2;
  logic               norm_err;
  logic               x1_bad, y1_bad, x2_bad, y2_bad;

  assign x1_bad = (raw_x1 > X_LIM);
  assign y1_bad = (raw_y1 > Y_LIM);
  assign x2_bad = (raw_x2 > X_LIM);
  assign y2_bad = (raw_y2 > Y_LIM);

  always_comb begin
    norm_x1  = raw_x1;
    norm_y1  = raw_y1;
    norm_x2  = raw_x2;
    norm_y2  = raw_y2;
    norm_err = 1'b0;
    case (raw_op)
      OP_LINE: begin
        norm_err = x1_bad || y1_bad || x2_bad || y2_bad;
      end
      OP_RECT: begin
        norm_err = x1_bad || y1_bad || x2_bad || y2_bad;
        norm_x1  = (raw_x1 < raw_x2) ? raw_x1 : raw_x2;
        norm_x2  = (raw_x1 < raw_x2) ? raw_x2 : raw_x1;
        norm_y1  = (raw_y1 < raw_y2) ? raw_y1 : raw_y2;
        norm_y2  = (raw_y1 < raw_y2) ? raw_y2 : raw_y1;
      end
      OP_POINT: begin
        norm_err = x1_bad || y1_bad;
        norm_x2  = raw_x1;
        norm_y2  = raw_y1;
      end
      OP_CLEAR: begin
        norm_x1 = '0;
        norm_y1 = '0;
        norm_x2 = X_LIM;
        norm_y2 = Y_LIM;
      end
      default: norm_err = 1'b0;
    endcase
  end

  logic [COORD_W-1:0]   x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic [1:0]           draw_mode_q, draw_mode_d;
  logic                 cmd_err_q, cmd_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // Draw outputs only change in CHECK, so they are stable throughout ISSUE and after it.
  always_comb begin
    state_d     = state_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    x2_d        = x2_q;
    y2_d        = y2_q;
    color_d     = color_q;
    draw_mode_d = draw_mode_q;
    cmd_err_d   = 1'b0;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = CHECK;
      end
      CHECK: begin
        if (norm_err) begin
          cmd_err_d   = 1'b1;
          err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + ERR_CNT_W'(1);
          state_d     = IDLE;
        end else begin
          x1_d        = norm_x1;
          y1_d        = norm_y1;
          x2_d        = norm_x2;
          y2_d        = norm_y2;
          color_d     = raw_color;
          draw_mode_d = raw_op;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (draw_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x1_q        <= '0;
      y1_q        <= '0;
      x2_q        <= '0;
      y2_q        <= '0;
      color_q     <= '0;
      draw_mode_q <= '0;
      cmd_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      x2_q        <= x2_d;
      y2_q        <= y2_d;
      color_q     <= color_d;
      draw_mode_q <= draw_mode_d;
      cmd_err_q   <= cmd_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign x1         = x1_q;
  assign y1         = y1_q;
  assign x2         = x2_q;
  assign y2         = y2_q;
  assign color      = color_q;
  assign draw_mode  = draw_mode_q;
  assign draw_valid = (state_q == ISSUE);
  assign cmd_err    = cmd_err_q;
  assign err_count  = err_count_q;
  assign busy       = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_gpu_cmd_decoder.sv
// tb/tb_gpu_cmd_decoder.sv - directed scoreboard bench for gpu_cmd_decoder
module tb_gpu_cmd_decoder;

  typedef struct packed {
    logic [1:0] mode;
    logic [8:0] x1;
    logic [8:0] y1;
    logic [8:0] x2;
    logic [8:0] y2;
    logic [7:0] color;
  } job_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [45:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  x1, y1, x2, y2;
  logic [7:0]  color;
  logic [1:0]  draw_mode;
  logic        draw_valid;
  logic        draw_ready = 1'b0;
  logic        cmd_err;
  logic [7:0]  err_count;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   err_pulses = 0;
  int   exp_drops = 0;
  job_t sb[$];
  job_t dut_job;
  job_t stall_job;
  logic stall_prev = 1'b0;

  always #5 clk = ~clk;

  gpu_cmd_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .x1         (x1),
    .y1         (y1),
    .x2         (x2),
    .y2         (y2),
    .color      (color),
    .draw_mode  (draw_mode),
    .draw_valid (draw_valid),
    .draw_ready (draw_ready),
    .cmd_err    (cmd_err),
    .err_count  (err_count),
    .busy       (busy)
  );

  assign dut_job = {draw_mode, x1, y1, x2, y2, color};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [8:0] a, b, c, d,
                                input logic [7:0] col, output bit err, output job_t j);
    err = 1'b0;
    j   = {op, a, b, c, d, col};
    case (op)
      2'd0: err = (a > 319) || (c > 319) || (b > 239) || (d > 239);
      2'd1: begin
        err = (a > 319) || (c > 319) || (b > 239) || (d > 239);
        j = {op, (a < c ? a : c), (b < d ? b : d), (a < c ? c : a), (b < d ? d : b), col};
      end
      2'd2: begin
        err = (a > 319) || (b > 239);
        j = {op, a, b, a, b, col};
      end
      default: j = {op, 9'd0, 9'd0, 9'd319, 9'd239, col};
    endcase
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one command, waits for acceptance, and records the expected outcome.
  task automatic send(input logic [1:0] op, input logic [8:0] a, b, c, d, input logic [7:0] col);
    int   n = 0;
    bit   err;
    job_t j;
    cmd_data  = {op, a, b, c, d, col};
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    chk("send_timeout", 64'(n < 50), 64'd1);
    step();
    cmd_valid = 1'b0;
    model(op, a, b, c, d, col, err, j);
    if (err) exp_drops++;
    else sb.push_back(j);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || draw_valid) && n < 400) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(n < 400), 64'd1);
  endtask

  // Monitor: scoreboard pop on every transfer, hold check during stalls, cmd_err pulse count.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("stall_hold", {draw_valid, dut_job}, {1'b1, stall_job});
      if (cmd_err) err_pulses++;
      if (draw_valid && draw_ready) begin
        chk("job_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) chk("job", dut_job, sb.pop_front());
      end
      stall_prev = draw_valid && !draw_ready;
      stall_job  = dut_job;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    step(3);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_draw_valid", draw_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_fields", dut_job, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    draw_ready = 1'b1;
    send(2'd0, 9'd10, 9'd20, 9'd300, 9'd200, 8'hAB);
    chk("lat_c1_valid", draw_valid, 0);
    chk("lat_c1_busy", busy, 1);
    step();
    chk("lat_c2_valid", draw_valid, 0);
    step();
    chk("lat_c3_valid", draw_valid, 1);
    step();
    chk("lat_c4_valid", draw_valid, 0);
    chk("lat_c4_busy", busy, 0);

    send(2'd1, 9'd200, 9'd150, 9'd5, 9'd7, 8'h55);
    wait_idle();
    send(2'd2, 9'd319, 9'd239, 9'h1FF, 9'h1FF, 8'h77);
    wait_idle();

    send(2'd0, 9'd10, 9'd20, 9'd320, 9'd200, 8'h11);
    step(2);
    chk("err_pulse_c3", cmd_err, 1);
    chk("err_count_1", err_count, 1);
    chk("err_no_valid", draw_valid, 0);
    step();
    chk("err_pulse_c4", cmd_err, 0);

    send(2'd3, 9'h1AB, 9'h0CD, 9'h012, 9'h1FF, 8'h3C);
    wait_idle();
    chk("clear_hold_after", dut_job, {2'd3, 9'd0, 9'd0, 9'd319, 9'd239, 8'h3C});

    draw_ready = 1'b0;
    send(2'd0, 9'd1, 9'd2, 9'd3, 9'd4, 8'h01);
    send(2'd1, 9'd9, 9'd8, 9'd7, 9'd6, 8'h02);
    send(2'd2, 9'd100, 9'd100, 9'd0, 9'd0, 8'h03);
    send(2'd3, 9'd5, 9'd5, 9'd5, 9'd5, 8'h04);
    chk("bp_ready_before_5th", cmd_ready, 1);
    send(2'd0, 9'd319, 9'd239, 9'd0, 9'd0, 8'h05);
    chk("bp_full_ready", cmd_ready, 0);
    chk("bp_valid", draw_valid, 1);
    chk("bp_busy", busy, 1);
    cmd_data  = {2'd0, 9'd50, 9'd50, 9'd60, 9'd60, 8'h66};
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_sixth_blocked", cmd_ready, 0);
      step();
    end
    cmd_valid  = 1'b0;
    draw_ready = 1'b1;
    step();
    chk("ready_not_comb", cmd_ready, 0);
    step();
    chk("ready_after_pop", cmd_ready, 1);
    wait_idle();
    step(2);
    chk("sb_drained", sb.size(), 0);

    for (int i = 0; i < 260; i++) send(2'd2, 9'h1FF, 9'd0, 9'd0, 9'd0, 8'hEE);
    wait_idle();
    step(2);
    chk("err_count_sat", err_count, 255);
    chk("err_pulses", err_pulses, exp_drops);

    draw_ready = 1'b0;
    send(2'd0, 9'd11, 9'd12, 9'd13, 9'd14, 8'hA1);
    send(2'd0, 9'd21, 9'd22, 9'd23, 9'd24, 8'hA2);
    send(2'd0, 9'd31, 9'd32, 9'd33, 9'd34, 8'hA3);
    chk("mid_issue_valid", draw_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", cmd_ready, 0);
    step();
    chk("mid_rst_valid", draw_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err_count", err_count, 0);
    sb.delete();
    reset      = 1'b0;
    draw_ready = 1'b1;
    step(10);
    chk("post_rst_valid", draw_valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
